// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle shared by the divider and its requester.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic signed [2*WIDTH-1:0] dividend;
    logic signed [WIDTH-1:0]   divisor;
    logic                      start;
    logic signed [WIDTH-1:0]   quo;
    logic signed [WIDTH-1:0]   rem;
    logic                      ready;
    logic                      div0;
    logic                      ovf;

    modport master (
        output dividend, divisor, start,
        input  quo, rem, ready, div0, ovf
    );

    modport slave (
        input  dividend, divisor, start,
        output quo, rem, ready, div0, ovf
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One unsigned restoring step: trial-subtract the divisor from the shifted partial remainder.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH-1:0] diff;

    // The partial remainder is always below the divisor, so a successful
    // subtraction never needs more than WIDTH bits.
    assign diff  = rem_i[WIDTH-1:0] - dvs_i;
    assign q_o   = (rem_i >= {1'b0, dvs_i});
    assign rem_o = q_o ? diff : rem_i[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider, one restoring step per clock; quotient truncates toward zero.
// Remainder output is built only when DIVIDER_REM_EN is defined, otherwise it reads 0.
//   state | meaning
//   IDLE  | results valid, waiting for start
//   CALC  | WIDTH unsigned restoring steps on the magnitudes
//   FIX   | sign correction, error masking, results registered
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int                CNT_BITS = cnt_width(WIDTH);
    localparam logic [CNT_BITS-1:0] LAST   = CNT_BITS'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  HALF     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  HALF_M1  = {1'b0, {(WIDTH-1){1'b1}}};

    state_t              state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [WIDTH-1:0]    acc_q;
    logic [WIDTH-1:0]    qsh_q;
    logic [WIDTH-1:0]    dvs_q;
    logic                qneg_q;
    logic                div0_pend_q;
    logic                pre_ovf_q;
    logic [WIDTH-1:0]    quo_q;
    logic                div0_q;
    logic                ovf_q;
    logic                ready_q;
`ifdef DIVIDER_REM_EN
    logic                rneg_q;
    logic [WIDTH-1:0]    rem_q;
    logic [WIDTH-1:0]    rem_fix;
`endif

    logic [2*WIDTH-1:0]  dvd_mag;
    logic [WIDTH-1:0]    dvs_mag;
    logic [WIDTH-1:0]    step_rem;
    logic                step_q;
    logic                post_ovf;
    logic                op_ovf;
    logic                op_err;
    logic [WIDTH-1:0]    quo_fix;

    // Magnitudes are unsigned at full width so the most negative operand survives.
    assign dvd_mag = bus.dividend[2*WIDTH-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag = bus.divisor[WIDTH-1]    ? -bus.divisor  : bus.divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (({acc_q, qsh_q[WIDTH-1]})),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // A negative quotient may reach one step further than a positive one.
    assign post_ovf = qneg_q ? (qsh_q > HALF) : (qsh_q > HALF_M1);
    assign op_ovf   = !div0_pend_q && (pre_ovf_q || post_ovf);
    assign op_err   = div0_pend_q || op_ovf;
    assign quo_fix  = qneg_q ? -qsh_q : qsh_q;
`ifdef DIVIDER_REM_EN
    assign rem_fix  = rneg_q ? -acc_q : acc_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            qsh_q       <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            div0_pend_q <= 1'b0;
            pre_ovf_q   <= 1'b0;
            quo_q       <= '0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ready_q     <= 1'b1;
`ifdef DIVIDER_REM_EN
            rneg_q      <= 1'b0;
            rem_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q       <= dvd_mag[2*WIDTH-1:WIDTH];
                        qsh_q       <= dvd_mag[WIDTH-1:0];
                        dvs_q       <= dvs_mag;
                        qneg_q      <= bus.dividend[2*WIDTH-1] ^ bus.divisor[WIDTH-1];
                        div0_pend_q <= (bus.divisor == '0);
                        pre_ovf_q   <= (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);
                        cnt_q       <= '0;
                        ready_q     <= 1'b0;
                        state_q     <= CALC;
`ifdef DIVIDER_REM_EN
                        rneg_q      <= bus.dividend[2*WIDTH-1];
`endif
                    end
                end
                CALC: begin
                    acc_q <= step_rem;
                    qsh_q <= {qsh_q[WIDTH-2:0], step_q};
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_BITS'(1);
                    end
                end
                FIX: begin
                    quo_q   <= op_err ? '0 : quo_fix;
                    div0_q  <= div0_pend_q;
                    ovf_q   <= op_ovf;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
`ifdef DIVIDER_REM_EN
                    rem_q   <= op_err ? '0 : rem_fix;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.quo   = quo_q;
    assign bus.div0  = div0_q;
    assign bus.ovf   = ovf_q;
    assign bus.ready = ready_q;
`ifdef DIVIDER_REM_EN
    assign bus.rem   = rem_q;
`else
    assign bus.rem   = '0;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: arithmetic reference model, decoupled result monitor.
module tb_seq_divider;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst_n), .bus(bus.slave));

    typedef struct {
        int dvd;
        int dvs;
        int quo;
        int rem;
        int div0;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Plain integer division: / truncates toward zero, % follows the dividend.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   q;
        e.dvd = a; e.dvs = b; e.quo = 0; e.rem = 0; e.div0 = 0; e.ovf = 0;
        if (b == 0) begin
            e.div0 = 1;
        end else begin
            q = a / b;
            if (q < -(1 << (W-1)) || q > (1 << (W-1)) - 1) begin
                e.ovf = 1;
            end else begin
                e.quo = q;
`ifdef DIVIDER_REM_EN
                e.rem = a % b;
`endif
            end
        end
        return e;
    endfunction

    task automatic issue(input int a, input int b, input bit expect_it);
        int                      t;
        logic signed [2*W-1:0]   a_s;
        logic signed [W-1:0]     b_s;
        t   = 0;
        a_s = a[2*W-1:0];
        b_s = b[W-1:0];
        @(negedge clk);
        while (!bus.ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            tests++; fails++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
        end
        bus.dividend = a_s;
        bus.divisor  = b_s;
        bus.start    = 1'b1;
        if (expect_it) sb.push_back(model(int'(a_s), int'(b_s)));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        bit   prev_rdy;
        int   busy, snap, cur, aq, ar;
        prev_rdy = 1'b1; busy = 0; snap = 0;
        forever begin
            @(negedge clk);
            cur = int'({bus.quo, bus.rem, bus.div0, bus.ovf});
            if (!rst_n) begin
                prev_rdy = 1'b1; busy = 0; snap = cur;
            end else if (!bus.ready) begin
                busy++;
                prev_rdy = 1'b0;
            end else if (!prev_rdy) begin
                chk("busy_cycles", busy, W + 1);
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_result: got quo=%0d expected no result", $signed(bus.quo));
                end else begin
                    e  = sb.pop_front();
                    aq = int'($signed(bus.quo));
                    ar = int'($signed(bus.rem));
                    chk($sformatf("quo %0d/%0d", e.dvd, e.dvs), aq, e.quo);
                    chk($sformatf("rem %0d/%0d", e.dvd, e.dvs), ar, e.rem);
                    chk($sformatf("div0 %0d/%0d", e.dvd, e.dvs), int'(bus.div0), e.div0);
                    chk($sformatf("ovf %0d/%0d", e.dvd, e.dvs), int'(bus.ovf), e.ovf);
`ifdef DIVIDER_REM_EN
                    if (e.div0 == 0 && e.ovf == 0) begin
                        chk("recompose", aq * e.dvs + ar, e.dvd);
                        chk("rem_mag", int'((ar < 0 ? -ar : ar) < (e.dvs < 0 ? -e.dvs : e.dvs)), 1);
                    end
`endif
                end
                busy = 0; snap = cur; prev_rdy = 1'b1;
            end else begin
                chk("hold_outputs", cur, snap);
            end
        end
    end

    initial begin : stim
        int a, b, q, rm, p, t;
        bus.dividend = '0; bus.divisor = '0; bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_ready", int'(bus.ready), 1);
        chk("rst_quo", int'(bus.quo), 0);
        chk("rst_rem", int'(bus.rem), 0);
        chk("rst_div0", int'(bus.div0), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(100, 7, 1);
        issue(-100, 7, 1);
        issue(100, -7, 1);
        issue(-16384, -128, 1);
        issue(16384, -128, 1);
        issue(-16384, 128, 1);
        issue(32767, 1, 1);
        issue(5, 0, 1);
        issue(-32768, -1, 1);
        issue(-129, -128, 1);
        issue(-32768, 127, 1);
        issue(16256, 127, 1);

        // start pulse with new operands in the middle of CALC must be ignored
        issue(1000, 9, 1);
        repeat (3) @(negedge clk);
        bus.dividend = 16'sd7; bus.divisor = 8'sd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // reset in cycle 4 of CALC aborts at once
        issue(-100, 7, 1);
        issue(77, 3, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ready", int'(bus.ready), 1);
        chk("abort_quo", int'(bus.quo), 0);
        chk("abort_rem", int'(bus.rem), 0);
        chk("abort_div0", int'(bus.div0), 0);
        chk("abort_ovf", int'(bus.ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            if (i % 2 == 0) begin
                b = int'($urandom_range(0, 255)) - 128;
                if (b == 0) b = 1;
                q  = int'($urandom_range(0, 255)) - 128;
                t  = (b < 0) ? -b : b;
                rm = (t > 1) ? int'($urandom_range(0, t - 1)) : 0;
                p  = q * b;
                if (p < 0 || (p == 0 && $urandom_range(0, 1) == 1)) rm = -rm;
                a  = p + rm;
            end else begin
                a = int'($urandom_range(0, 65535)) - 32768;
                b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
            end
            issue(a, b, 1);
        end

        t = 0;
        while ((sb.size() != 0 || !bus.ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: got %0d pending results expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
